// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath:
// state codes, opcode/funct values and the ALU/PC select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_BREAK = 6'h0D;

  localparam logic [1:0] ALUB_REG     = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // One bundle for every datapath enable/select the controller drives.
  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles spent waiting on an access and flags
// 'expired' on the last permitted wait cycle.
module mc_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// bounds every memory wait, and retires instructions into instr_cnt.
module mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  state_e           state_q, state_d;
  logic             run_q;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;

  logic timer_clear;
  logic mem_wait;
  logic mem_timeout;
  logic expired;

  // run_q keeps FETCH quiet while reset is held; the first edge after
  // release starts the fetch.
  assign mem_wait    = run_q && is_mem_state(state_q);
  assign mem_timeout = mem_wait && !mem_ready && expired;
  assign timer_clear = (state_d != state_q);

  mc_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (mem_wait),
    .expired (expired)
  );

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned and infers a latch.
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    ctrl      = CTRL_IDLE;

    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = run_q;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        if (mem_wait && mem_ready) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALUB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (funct == FUNCT_BREAK) ? S_HALT : S_RTEXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_RTEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_RTWB;
      end
      S_RTWB: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_we     = zero;
        state_d        = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_we = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_we  = 1'b1;
        ctrl.pc_src = PCSRC_JUMP;
        state_d     = S_FETCH;
      end
      // HALT and the unused codes are absorbing with everything idle.
      default: state_d = S_HALT;
    endcase

    // A timeout only wins when mem_ready is absent on the expiring cycle.
    if (mem_timeout) begin
      state_d   = S_HALT;
      mem_err_d = 1'b1;
    end
  end

  assign cnt_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc_we      = ctrl.pc_we;
  assign ir_we      = ctrl.ir_we;
  assign reg_we     = ctrl.reg_we;
  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;

  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign mem_err   = mem_err_q;
  assign instr_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: each instruction is expanded into the
// expected per-cycle state/enable trace and compared cycle by cycle.
module tb_mc_control;

  localparam int TMO         = 15;
  localparam int HALT_CYCLES = 20;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                 ST_MEMWB = 4, ST_MEMWR = 5, ST_RTEXEC = 6, ST_RTWB = 7,
                 ST_BRANCH = 8, ST_ADDIEX = 9, ST_ADDIWB = 10, ST_JUMP = 11,
                 ST_HALT = 12;

  localparam logic [5:0] T_RT = 6'h00, T_J = 6'h02, T_BEQ = 6'h04,
                         T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2B;
  localparam logic [5:0] T_BREAK = 6'h0D, T_ADD = 6'h20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_we, ir_we, reg_we, mem_req, mem_we, iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        halted, illegal, mem_err;
  logic [31:0] instr_cnt;
  logic [3:0]  state;

  mc_control #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .halted(halted), .illegal(illegal),
    .mem_err(mem_err), .instr_cnt(instr_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Expected trace, one entry per clock cycle.
  int          q_state[$];
  bit          q_ready[$];
  logic [31:0] q_cnt[$];
  logic [2:0]  q_flags[$];   // {halted, illegal, mem_err}

  logic [31:0] m_cnt   = '0;
  logic [2:0]  m_flags = '0;
  logic [5:0]  cur_op = '0, cur_fn = '0;
  bit          cur_zero = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_mem(input int st);
    return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
  endfunction

  // {pc_we, ir_we, reg_we, mem_req, mem_we, reg_dst, mem_to_reg}
  function automatic logic [6:0] exp_en(input int st, input bit rdy, input bit z);
    case (st)
      ST_FETCH:  return {rdy, rdy, 1'b0, 1'b1, 3'b000};
      ST_MEMRD:  return 7'b0001000;
      ST_MEMWR:  return 7'b0001100;
      ST_MEMWB:  return 7'b0010001;
      ST_RTWB:   return 7'b0010010;
      ST_ADDIWB: return 7'b0010000;
      ST_BRANCH: return {z, 6'b000000};
      ST_JUMP:   return 7'b1000000;
      default:   return 7'b0000000;
    endcase
  endfunction

  // {expected {alu_src_b, alu_op, pc_src}, care mask}
  function automatic logic [11:0] exp_sel(input int st, input bit rdy);
    case (st)
      ST_FETCH:  return rdy ? {6'b01_00_00, 6'b11_00_11} : 12'h000;
      ST_DECODE: return {6'b11_00_00, 6'b11_00_00};
      ST_MEMADR: return {6'b10_00_00, 6'b11_00_00};
      ST_ADDIEX: return {6'b10_00_00, 6'b11_00_00};
      ST_RTEXEC: return {6'b00_10_00, 6'b11_11_00};
      ST_BRANCH: return {6'b00_01_01, 6'b11_11_11};
      ST_JUMP:   return {6'b00_00_10, 6'b00_00_11};
      default:   return 12'h000;
    endcase
  endfunction

  task automatic push(input int st, input bit rdy);
    q_state.push_back(st);
    q_ready.push_back(rdy);
    q_cnt.push_back(m_cnt);
    q_flags.push_back(m_flags);
  endtask

  // lat idle cycles then ready; a wait that reaches TMO cycles fails.
  task automatic push_mem(input int st, input int lat, output bit ok);
    int n;
    ok = (lat < TMO);
    n  = ok ? lat + 1 : TMO;
    for (int i = 0; i < n; i++) push(st, ok && (i == n - 1));
  endtask

  task automatic push_halt(input logic [2:0] flags);
    m_flags = flags;
    for (int i = 0; i < HALT_CYCLES; i++) push(ST_HALT, 1'b0);
  endtask

  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int lat_f, input int lat_m);
    bit ok;
    push_mem(ST_FETCH, lat_f, ok);
    if (!ok) begin
      push_halt(3'b101);
      return;
    end
    push(ST_DECODE, 1'b0);
    case (op)
      T_LW: begin
        push(ST_MEMADR, 1'b0);
        push_mem(ST_MEMRD, lat_m, ok);
        if (ok) push(ST_MEMWB, 1'b0);
        else push_halt(3'b101);
      end
      T_SW: begin
        push(ST_MEMADR, 1'b0);
        push_mem(ST_MEMWR, lat_m, ok);
        if (!ok) push_halt(3'b101);
      end
      T_RT: begin
        if (fn == T_BREAK) begin
          push_halt(3'b100);
          ok = 1'b0;
        end else begin
          push(ST_RTEXEC, 1'b0);
          push(ST_RTWB, 1'b0);
        end
      end
      T_BEQ:  push(ST_BRANCH, 1'b0);
      T_ADDI: begin push(ST_ADDIEX, 1'b0); push(ST_ADDIWB, 1'b0); end
      T_J:    push(ST_JUMP, 1'b0);
      default: begin
        push_halt(3'b110);
        ok = 1'b0;
      end
    endcase
    if (ok) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic flush();
    q_state.delete();
    q_ready.delete();
    q_cnt.delete();
    q_flags.delete();
  endtask

  task automatic run_trace(input int max_cycles);
    int n;
    n = 0;
    while (q_state.size() > 0 && n < max_cycles) begin
      int          st;
      bit          rdy;
      logic [31:0] cnt;
      logic [2:0]  fl;
      logic [11:0] sel;
      st  = q_state.pop_front();
      rdy = q_ready.pop_front();
      cnt = q_cnt.pop_front();
      fl  = q_flags.pop_front();
      @(negedge clk);
      opcode    = cur_op;
      funct     = cur_fn;
      zero      = cur_zero;
      mem_ready = is_mem(st) ? rdy : 1'($urandom_range(0, 1));
      #1;
      sel = exp_sel(st, rdy);
      check("state", 64'(state), 64'(st));
      check("enables", 64'({pc_we, ir_we, reg_we, mem_req, mem_we, reg_dst, mem_to_reg}),
            64'(exp_en(st, rdy, cur_zero)));
      check("status", 64'({halted, illegal, mem_err}), 64'(fl));
      check("instr_cnt", 64'(instr_cnt), 64'(cnt));
      if (st == ST_MEMRD || st == ST_MEMWR) check("iord", 64'(iord), 64'd1);
      if (st == ST_FETCH) check("iord_fetch", 64'(iord), 64'd0);
      if (sel[5:0] != 6'd0)
        check("selects", 64'({alu_src_b, alu_op, pc_src} & sel[5:0]), 64'(sel[11:6]));
      n++;
    end
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input bit z,
                      input int lat_f, input int lat_m);
    cur_op   = op;
    cur_fn   = fn;
    cur_zero = z;
    plan(op, fn, lat_f, lat_m);
    run_trace(1000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_enables", 64'({pc_we, ir_we, reg_we, mem_req, mem_we}), 64'd0);
    check("rst_status", 64'({halted, illegal, mem_err}), 64'd0);
    check("rst_instr_cnt", 64'(instr_cnt), 64'd0);
    flush();
    m_cnt   = '0;
    m_flags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_before_first_edge", 64'({state, mem_req}), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{T_LW, T_SW, T_RT, T_BEQ, T_ADDI, T_J};

    #2;
    do_reset();

    // addi then add with zero wait
    step(T_ADDI, 6'h00, 1'b0, 0, 0);
    step(T_RT, T_ADD, 1'b0, 0, 0);
    // lw with a 3-cycle read wait
    step(T_LW, 6'h00, 1'b0, 0, 3);
    // taken then untaken branch
    step(T_BEQ, 6'h00, 1'b1, 0, 0);
    step(T_BEQ, 6'h00, 1'b0, 1, 0);
    step(T_SW, 6'h00, 1'b0, 2, 2);
    step(T_J, 6'h00, 1'b0, 0, 0);

    // random mix with random wait latencies
    for (int i = 0; i < 40; i++) begin
      logic [5:0] fn;
      fn = 6'($urandom_range(0, 63));
      if (fn == T_BREAK) fn = T_ADD;
      step(ops[$urandom_range(0, 5)], fn, 1'($urandom_range(0, 1)),
           $urandom_range(0, 6), $urandom_range(0, 6));
    end

    // ready on the final permitted fetch cycle completes normally
    step(T_ADDI, 6'h00, 1'b0, TMO - 1, 0);
    step(T_LW, 6'h00, 1'b0, 0, TMO - 1);
    // fetch never answered
    step(T_ADDI, 6'h00, 1'b0, TMO, 0);
    do_reset();

    // read never answered
    step(T_ADDI, 6'h00, 1'b0, 0, 0);
    step(T_LW, 6'h00, 1'b0, 0, TMO);
    do_reset();

    // break halts cleanly
    step(T_J, 6'h00, 1'b0, 0, 0);
    step(T_RT, T_BREAK, 1'b0, 0, 0);
    do_reset();

    // illegal opcode
    step(T_ADDI, 6'h00, 1'b0, 0, 0);
    step(6'h3F, 6'h00, 1'b0, 0, 0);
    do_reset();

    // reset in the middle of a store
    step(T_ADDI, 6'h00, 1'b0, 0, 0);
    cur_op = T_SW;
    cur_fn = 6'h00;
    plan(T_SW, 6'h00, 0, 8);
    run_trace(5);
    check("mid_store_mem_we", 64'(mem_we), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 64'(state), 64'd0);
    check("async_rst_mem_we", 64'({mem_we, mem_req}), 64'd0);
    check("async_rst_instr_cnt", 64'(instr_cnt), 64'd0);
    do_reset();
    step(T_LW, 6'h00, 1'b0, 1, 1);
    step(T_BEQ, 6'h00, 1'b1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready per access.
REQ-002 Parameter CNT_W, default 32: width of instr_cnt.
REQ-003 Port clk, input, 1: single system clock; all state changes on posedge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port opcode, input, 6: IR[31:26] of the latched instruction.
REQ-006 Port funct, input, 6: IR[5:0]; used only to detect R-type halt (funct 0x0D, break).
REQ-007 Port zero, input, 1: ALU zero flag.
REQ-008 Port mem_ready, input, 1: memory completes the current access this cycle.
REQ-009 Ports pc_we, ir_we, reg_we, mem_req, mem_we, iord, reg_dst, mem_to_reg, alu_src_a, output, 1 each: standard multicycle datapath enables and selects.
REQ-010 Ports alu_src_b, alu_op, pc_src, output, 2 each: ALU B select (0 reg, 1 const 4, 2 sign-ext imm, 3 imm<<2), ALU op (0 add, 1 sub, 2 funct), PC source (0 ALU, 1 ALUOut, 2 jump target).
REQ-011 Ports halted, illegal, mem_err, output, 1 each: terminal status flags.
REQ-012 Port instr_cnt, output, CNT_W: retired-instruction count.
REQ-013 Port state, output, 4: current state code, for debug.

Function
REQ-014 The FSM SHALL use these states and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALT 12.
REQ-015 FETCH SHALL assert mem_req with iord=0 and hold it until mem_ready; on that cycle it SHALL assert ir_we and pc_we (alu_src_b=1, pc_src=0) and move to DECODE.
REQ-016 DECODE SHALL compute the branch target (alu_src_b=3) and dispatch on opcode:
- 0x23/0x2B -> MEMADR
- 0x00 -> RTEXEC, or HALT if funct=0x0D
- 0x04 -> BRANCH
- 0x08 -> ADDIEX
- 0x02 -> JUMP
- any other opcode -> HALT with illegal=1
REQ-017 MEMADR SHALL go to MEMRD for lw and to MEMWR for sw.
REQ-018 MEMRD and MEMWR SHALL hold mem_req (iord=1, mem_we=1 in MEMWR only) until mem_ready; MEMRD then goes to MEMWB, and MEMWR goes to FETCH.
REQ-019 MEMWB, RTWB and ADDIWB SHALL pulse reg_we for exactly one cycle, then go to FETCH; reg_dst is 1 only in RTWB, and mem_to_reg is 1 only in MEMWB.
REQ-020 BRANCH SHALL use alu_op=1 and pc_src=1, assert pc_we only if zero=1, then go to FETCH.
REQ-021 JUMP SHALL assert pc_we with pc_src=2, then go to FETCH.
REQ-022 instr_cnt SHALL increment by one on each transition into FETCH from a non-FETCH state; it wraps modulo 2^CNT_W.
REQ-023 A wait counter SHALL clear on entry to each memory state; if it reaches MEM_TIMEOUT without mem_ready, the FSM SHALL go to HALT with mem_err=1 and no enables asserted.
REQ-024 mem_ready arriving on the same edge as the timeout SHALL take precedence: the access completes normally.
REQ-025 HALT SHALL be absorbing: halted=1, every enable and mem_req low, and instr_cnt frozen until reset.
REQ-026 All enables SHALL be Moore outputs decoded from state, except the conditional pc_we in BRANCH and the mem_ready-qualified ir_we/pc_we in FETCH.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state=FETCH, instr_cnt=0, halted=0, illegal=0, mem_err=0, wait counter=0, and all enables low, including mid-access.
REQ-028 After rst_n deasserts, the first rising edge SHALL begin a fetch with mem_req=1.

Structure
REQ-029 State codes, opcode/funct constants and the alu_src_b/alu_op/pc_src encodings SHALL live in shared package mips_ctrl_pkg, also used by the datapath.
REQ-030 The wait/timeout counter SHALL be a separate sub-module, mc_wait_timer (clear, enable, expired).

Verification
REQ-031 addi then R-type add with mem_ready tied high -> state sequence 0,1,9,10,0,1,6,7,0; reg_we high one cycle in each writeback; instr_cnt=2.
REQ-032 lw with mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles, reg_we with mem_to_reg=1 one cycle later, no mem_err.
REQ-033 beq with zero=1, then beq with zero=0 -> pc_we=1 with pc_src=1 in the first BRANCH only; pc_we=0 in the second.
REQ-034 opcode 0x3F -> HALT, illegal=1, halted=1; 20 further cycles show no enables and no instr_cnt change.
REQ-035 mem_ready held low in FETCH -> HALT with mem_err=1 after exactly 15 wait cycles; mem_ready on cycle 15 instead -> normal DECODE.
REQ-036 rst_n pulsed low mid-MEMWR -> state=0, mem_we=0 asynchronously, instr_cnt=0, normal fetch after release.
